// File: rtl/pif_serial_port_gen_if.sv
// Serial line and PIF RAM port bundle for pif_serial_port_gen.
// The slave modport is the port side; the master modport is the pins/RAM side.
interface pif_serial_port_gen_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 9
);
    logic              ser_in;
    logic              ser_out;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    modport slave (
        input  ser_in,
        input  mem_rdata,
        output ser_out,
        output mem_addr,
        output mem_wren,
        output mem_wdata
    );

    modport master (
        output ser_in,
        output mem_rdata,
        input  ser_out,
        input  mem_addr,
        input  mem_wren,
        input  mem_wdata
    );
endinterface

// File: rtl/pif_serial_port_gen.sv
// PIF serial-port slave: decodes {type, addr} headers from ser_in and streams PIF RAM words.
// Define PIF_SERIAL_PARITY_EN to add one even-parity bit after every word in both directions.
module pif_serial_port_gen #(
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned BURST_WORDS  = 16,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned TIMEOUT_BITS = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    pif_serial_port_gen_if.slave        bus,
    input  logic                        burst_hold_i,
    input  logic                        err_clr_i,
    output logic                        busy_o,
    output logic [1:0]                  last_type_o,
    output logic                        err_timeout_o,
    output logic                        err_parity_o
);

    localparam int unsigned HDR_LEN = 2 + ADDR_W;
`ifdef PIF_SERIAL_PARITY_EN
    localparam int unsigned LEN   = WORD_W + 1;
    localparam int unsigned WSH_W = WORD_W;
`else
    localparam int unsigned LEN   = WORD_W;
    localparam int unsigned WSH_W = WORD_W - 1;
`endif
    localparam int unsigned MAXB   = (LEN > HDR_LEN) ? LEN : HDR_LEN;
    localparam int unsigned BIT_W  = $clog2(MAXB);
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned WCNT_W = $clog2(BURST_WORDS);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_BITS + 1);

    typedef enum logic [2:0] {
        StIdle, StHdr, StDecode, StRdAck, StRdData, StWrAck, StWrWait, StWrData
    } state_e;

    state_e              state_q;
    logic [1:0]          sync_q;
    logic                prev_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BIT_W-1:0]    bitn_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                skip_q;
    logic [HDR_LEN-1:0]  hdr_q;
    logic [LEN-1:0]      sh_q;
    logic [WSH_W-1:0]    wsh_q;
    logic                ser_out_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wren_q;
    logic                inc_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [1:0]          type_q;
    logic                tmo_err_q;

    logic                ser_s;
    logic                fall;
    logic [CNT_W-1:0]    bc;
    logic                mid;
    logic                eob;
    logic                last_word;
    logic [LEN-1:0]      ld;

    // A detected falling edge is treated as bit-counter 0 in the same clk.
    always_comb begin
        ser_s     = sync_q[1];
        fall      = prev_q & ~ser_s;
        bc        = fall ? '0 : cnt_q;
        mid       = (bc == CNT_W'(CLKS_PER_BIT / 2));
        eob       = (bc == CNT_W'(CLKS_PER_BIT - 1));
        last_word = type_q[1] || (wcnt_q == WCNT_W'(BURST_WORDS - 1));
`ifdef PIF_SERIAL_PARITY_EN
        ld        = {bus.mem_rdata, ^bus.mem_rdata};
`else
        ld        = bus.mem_rdata;
`endif
    end

`ifdef PIF_SERIAL_PARITY_EN
    logic par_err_q;
    assign err_parity_o = par_err_q;
`else
    assign err_parity_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            cnt_q     <= '0;
            bitn_q    <= '0;
            wcnt_q    <= '0;
            tmo_q     <= '0;
            skip_q    <= 1'b0;
            hdr_q     <= '0;
            sh_q      <= '0;
            wsh_q     <= '0;
            ser_out_q <= 1'b1;
            addr_q    <= '0;
            wren_q    <= 1'b0;
            inc_q     <= 1'b0;
            wdata_q   <= '0;
            type_q    <= '0;
            tmo_err_q <= 1'b0;
`ifdef PIF_SERIAL_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            sync_q <= {sync_q[0], bus.ser_in};
            prev_q <= ser_s;
            cnt_q  <= eob ? '0 : bc + 1'b1;
            wren_q <= 1'b0;
            inc_q  <= 1'b0;
            if (inc_q) addr_q <= addr_q + 1'b1;
            if (err_clr_i) begin
                tmo_err_q <= 1'b0;
`ifdef PIF_SERIAL_PARITY_EN
                par_err_q <= 1'b0;
`endif
            end
            unique case (state_q)
                StIdle: begin
                    ser_out_q <= 1'b1;
                    if (fall) begin
                        state_q <= StHdr;
                        skip_q  <= 1'b1;
                        bitn_q  <= '0;
                    end
                end
                StHdr: begin
                    if (mid && !skip_q) hdr_q <= {hdr_q[HDR_LEN-2:0], ser_s};
                    if (eob) begin
                        if (skip_q) begin
                            skip_q <= 1'b0;
                        end else if (bitn_q == BIT_W'(HDR_LEN - 1)) begin
                            state_q <= StDecode;
                            addr_q  <= hdr_q[ADDR_W-1:0];
                            type_q  <= hdr_q[HDR_LEN-1 -: 2];
                        end else begin
                            bitn_q <= bitn_q + 1'b1;
                        end
                    end
                end
                StDecode: begin
                    // Leaving DECODE restarts the bit counter so the ack is a full bit period.
                    if (!(burst_hold_i && !type_q[1])) begin
                        state_q   <= type_q[0] ? StRdAck : StWrAck;
                        ser_out_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                StRdAck: begin
                    if (eob) begin
                        state_q   <= StRdData;
                        ser_out_q <= ld[LEN-1];
                        sh_q      <= ld << 1;
                        bitn_q    <= '0;
                        wcnt_q    <= '0;
                    end
                end
                StRdData: begin
                    if (eob) begin
                        if (bitn_q == BIT_W'(LEN - 1)) begin
                            if (last_word) begin
                                state_q   <= StIdle;
                                ser_out_q <= 1'b1;
                            end else begin
                                ser_out_q <= ld[LEN-1];
                                sh_q      <= ld << 1;
                                bitn_q    <= '0;
                                wcnt_q    <= wcnt_q + 1'b1;
                            end
                        end else begin
                            ser_out_q <= sh_q[LEN-1];
                            sh_q      <= sh_q << 1;
                            bitn_q    <= bitn_q + 1'b1;
                            // Next address goes out a full bit period before its word is loaded.
                            if (bitn_q == BIT_W'(LEN - 2) && !last_word) addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                StWrAck: begin
                    if (eob) begin
                        state_q   <= StWrWait;
                        ser_out_q <= 1'b1;
                        tmo_q     <= '0;
                    end
                end
                StWrWait: begin
                    if (fall) begin
                        state_q <= StWrData;
                        skip_q  <= 1'b1;
                        bitn_q  <= '0;
                        wcnt_q  <= '0;
                    end else if (eob) begin
                        if (tmo_q == TMO_W'(TIMEOUT_BITS - 1)) begin
                            state_q   <= StIdle;
                            tmo_err_q <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                end
                StWrData: begin
                    if (mid && !skip_q) begin
                        if (bitn_q == BIT_W'(LEN - 1)) begin
                            inc_q <= 1'b1;
`ifdef PIF_SERIAL_PARITY_EN
                            wdata_q <= wsh_q;
                            if (^{wsh_q, ser_s}) par_err_q <= 1'b1;
                            else wren_q <= 1'b1;
`else
                            wdata_q <= {wsh_q, ser_s};
                            wren_q  <= 1'b1;
`endif
                        end else begin
                            wsh_q <= {wsh_q[WSH_W-2:0], ser_s};
                        end
                    end
                    if (eob) begin
                        if (skip_q) begin
                            skip_q <= 1'b0;
                        end else if (bitn_q == BIT_W'(LEN - 1)) begin
                            bitn_q <= '0;
                            if (last_word) state_q <= StIdle;
                            else wcnt_q <= wcnt_q + 1'b1;
                        end else begin
                            bitn_q <= bitn_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ser_out   = ser_out_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wren  = wren_q;
    assign bus.mem_wdata = wdata_q;
    assign busy_o        = (state_q != StIdle);
    assign last_type_o   = type_q;
    assign err_timeout_o = tmo_err_q;

endmodule

// File: tb/tb_pif_serial_port_gen.sv
// Scoreboard bench for pif_serial_port_gen: a serial master drives requests, monitors check
// RAM writes and read words against a word-level memory model.
module tb_pif_serial_port_gen;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned BURST   = 16;
    localparam int unsigned CPB     = 4;
    localparam int unsigned TMO     = 64;
    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned HDR_LEN = 2 + ADDR_W;
`ifdef PIF_SERIAL_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       burst_hold;
    logic       err_clr;
    logic       busy;
    logic [1:0] last_type;
    logic       err_timeout;
    logic       err_parity;

    pif_serial_port_gen_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    pif_serial_port_gen #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .BURST_WORDS(BURST),
        .CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TMO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .burst_hold_i(burst_hold), .err_clr_i(err_clr),
        .busy_o(busy), .last_type_o(last_type), .err_timeout_o(err_timeout),
        .err_parity_o(err_parity)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0]        ram   [DEPTH];
    logic [WORD_W-1:0]        model [DEPTH];
    logic [ADDR_W+WORD_W-1:0] exp_wr[$];
    logic [WORD_W-1:0]        exp_rd[$];
    int                       exp_n[$];   // per request: read word count, 0 = write ack

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    // RAM with one-clk read latency; written only by the DUT.
    always @(posedge clk) bus.mem_rdata <= ram[bus.mem_addr];

    // Write monitor.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.mem_wren === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr %0h data %0h", bus.mem_addr, bus.mem_wdata);
            end else begin
                check("wr_addr_data", {bus.mem_addr, bus.mem_wdata}, exp_wr.pop_front());
            end
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    // Read monitor: decodes the ack and read words from ser_out.
    initial begin : rd_mon
        logic [WORD_W-1:0] w;
        logic [WORD_W-1:0] e;
        int n;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && bus.ser_out === 1'b0) begin
                if (exp_n.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack ser_out low with no request pending");
                    n = 0;
                end else begin
                    n = exp_n.pop_front();
                end
                repeat (CPB / 2) @(negedge clk);
                check("ack_low", bus.ser_out, 1'b0);
                if (n == 0) begin
                    for (int k = 0; k < 4 * CPB && bus.ser_out !== 1'b1; k++) @(negedge clk);
                end else begin
                    for (int i = 0; i < n; i++) begin
                        w = '0;
                        for (int b = 0; b < WORD_W; b++) begin
                            repeat (CPB) @(negedge clk);
                            w = {w[WORD_W-2:0], bus.ser_out};
                        end
                        if (PAR != 0) begin
                            repeat (CPB) @(negedge clk);
                            check("rd_parity", bus.ser_out, ^w);
                        end
                        e = (exp_rd.size() != 0) ? exp_rd.pop_front() : 'x;
                        check("rd_word", w, e);
                    end
                    repeat (CPB / 2) @(negedge clk);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        bus.ser_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [1:0] t, input logic [ADDR_W-1:0] a);
        logic [HDR_LEN-1:0] h;
        h = {t, a};
        send_bit(1'b0);
        for (int i = HDR_LEN - 1; i >= 0; i--) send_bit(h[i]);
        bus.ser_in = 1'b1;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] d, input logic bad_par);
        for (int i = WORD_W - 1; i >= 0; i--) send_bit(d[i]);
        if (PAR != 0) send_bit((^d) ^ bad_par);
        bus.ser_in = 1'b1;
    endtask

    task automatic wait_ser(input logic v, input int budget, input string name);
        for (int k = 0; k < budget && bus.ser_out !== v; k++) @(negedge clk);
        check(name, bus.ser_out, v);
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int k = 0; k < budget && busy !== 1'b0; k++) @(negedge clk);
        check(name, busy, 1'b0);
    endtask

    task automatic wr_handshake();
        wait_ser(1'b0, 60, "wr_ack_low");
        wait_ser(1'b1, 2 * CPB, "wr_ack_end");
        send_bit(1'b0);
    endtask

    task automatic do_req(input logic [1:0] t, input logic [ADDR_W-1:0] a, input bit seq);
        int n;
        logic [WORD_W-1:0] d;
        logic [ADDR_W-1:0] wa;
        n = t[1] ? 1 : BURST;
        if (t[0]) begin
            exp_n.push_back(n);
            for (int i = 0; i < n; i++) exp_rd.push_back(model[ADDR_W'(a + i)]);
        end else begin
            exp_n.push_back(0);
        end
        send_hdr(t, a);
        if (!t[0]) begin
            wr_handshake();
            for (int i = 0; i < n; i++) begin
                d  = seq ? WORD_W'(i) : WORD_W'($urandom);
                wa = ADDR_W'(a + i);
                exp_wr.push_back({wa, d});
                model[wa] = d;
                send_word(d, 1'b0);
            end
        end
        wait_idle(n * (WORD_W + PAR + 1) * CPB + 100, "req_done");
        check("last_type", last_type, t);
    endtask

    initial begin : stim
        logic [WORD_W-1:0] v;
        logic [ADDR_W-1:0] a;
        int bad;
        reset      = 1'b1;
        bus.ser_in = 1'b1;
        burst_hold = 1'b0;
        err_clr    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            v = WORD_W'($urandom);
            ram[i]   = v;
            model[i] = v;
        end
        ram[5]   = 32'hDEADBEEF;
        model[5] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        check("rst_ser_out", bus.ser_out, 1'b1);
        check("rst_wren", bus.mem_wren, 1'b0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_last_type", last_type, 2'b00);
        check("rst_errs", {err_timeout, err_parity}, 2'b00);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        do_req(2'b11, 9'h005, 1'b0);
        do_req(2'b00, 9'h1F8, 1'b1);
        do_req(2'b01, 9'h1F8, 1'b0);
        for (int r = 0; r < 6; r++) do_req(2'($urandom_range(0, 3)), ADDR_W'($urandom), 1'b0);

        // Burst read stalled by burst_hold.
        burst_hold = 1'b1;
        a = ADDR_W'($urandom);
        exp_n.push_back(BURST);
        for (int i = 0; i < BURST; i++) exp_rd.push_back(model[ADDR_W'(a + i)]);
        send_hdr(2'b01, a);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.ser_out !== 1'b1 || busy !== 1'b1) bad++;
        end
        check("hold_stall", bad, 0);
        burst_hold = 1'b0;
        wait_idle(BURST * (WORD_W + PAR + 1) * CPB + 100, "hold_done");

        // Write-single with no start bit: timeout.
        exp_n.push_back(0);
        send_hdr(2'b10, 9'h033);
        wait_ser(1'b0, 60, "tmo_ack_low");
        wait_ser(1'b1, 2 * CPB, "tmo_ack_end");
        check("tmo_busy_before", busy, 1'b1);
        wait_idle(TMO * CPB + 100, "tmo_idle");
        check("err_timeout_set", err_timeout, 1'b1);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        check("err_timeout_clr", err_timeout, 1'b0);

`ifdef PIF_SERIAL_PARITY_EN
        exp_n.push_back(0);
        send_hdr(2'b10, 9'h044);
        wr_handshake();
        send_word(32'h00000001, 1'b1);
        wait_idle(200, "par_idle");
        check("err_parity_set", err_parity, 1'b1);
`else
        check("err_parity_tied", err_parity, 1'b0);
`endif

        // Reset in the middle of word 3 of a write burst.
        a = ADDR_W'($urandom);
        exp_n.push_back(0);
        send_hdr(2'b00, a);
        wr_handshake();
        for (int i = 0; i < 3; i++) begin
            v = WORD_W'($urandom);
            exp_wr.push_back({ADDR_W'(a + i), v});
            model[ADDR_W'(a + i)] = v;
            send_word(v, 1'b0);
        end
        v = WORD_W'($urandom);
        for (int i = WORD_W - 1; i >= WORD_W - 10; i--) send_bit(v[i]);
        reset = 1'b1;
        #1;
        check("midrst_ser_out", bus.ser_out, 1'b1);
        check("midrst_busy", busy, 1'b0);
        bus.ser_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        do_req(2'b11, ADDR_W'(a + 2), 1'b0);
        do_req(2'b11, ADDR_W'(a + 3), 1'b0);

        repeat (20) @(negedge clk);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);
        check("req_queue_empty", exp_n.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end
endmodule
